// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge port between the MEM pipeline stage and data memory.
// The stage drives through the master modport; the memory answers through slave.
interface memory_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, output we, output addr, output wdata, input rdata, input ack);
    modport slave  (input req, input we, input addr, input wdata, output rdata, output ack);
endinterface

// File: rtl/memory_access.sv
// MEM pipeline stage: EX/MEM register, variable-latency load/store port, MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN aborts word-misaligned accesses without touching memory.
module memory_access #(
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [31:0]     ex_alu_result,
    input  logic [31:0]     ex_write_data,
    input  logic [4:0]      ex_write_addr,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_mem_to_reg,
    input  logic            ex_reg_write,
    output logic            mem_stall,
    memory_access_if.master dmem,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [4:0]      wb_write_addr,
    output logic [31:0]     wb_write_data,
    output logic            mem_fault
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;

    logic             m_valid_r;
    logic [31:0]      m_alu_r;
    logic [31:0]      m_wdata_r;
    logic [4:0]       m_waddr_r;
    logic             m_read_r;
    logic             m_write_r;
    logic             m_to_reg_r;
    logic             m_reg_write_r;
    logic             m_misalign_r;

    logic             ex_misalign_s;
    logic             ex_issue_s;
    logic             m_store_s;
    logic             timeout_s;
    logic             stall_s;
    logic             fault_s;

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic word_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

    assign ex_misalign_s = ex_valid & (ex_mem_read | ex_mem_write) & word_misaligned(ex_alu_result[1:0]);
`else
    assign ex_misalign_s = 1'b0;
`endif

    // A memory op only reaches the port if it is live and passes the alignment gate.
    assign ex_issue_s = ex_valid & (ex_mem_read | ex_mem_write) & ~ex_misalign_s;
    // Read+write together is treated as a load.
    assign m_store_s  = m_write_r & ~m_read_r;
    assign timeout_s  = (state_r == ST_REQ) & ~dmem.ack & (cnt_r == CNT_W'(ACK_TIMEOUT - 1));
    assign stall_s    = (state_r == ST_REQ) & ~dmem.ack & ~timeout_s;
    assign fault_s    = timeout_s | (m_valid_r & m_misalign_r);

    assign mem_stall  = stall_s;
    assign dmem.req   = (state_r == ST_REQ);
    assign dmem.we    = (state_r == ST_REQ) & m_store_s;
    assign dmem.addr  = m_alu_r;
    assign dmem.wdata = m_wdata_r;

    // Next-state: completion or abort re-enters REQ directly when EX already holds a memory op.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ex_issue_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (stall_s) begin
                    state_nxt_s = ST_REQ;
                end else if (ex_issue_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and wait counter; the counter restarts whenever the stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (stall_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    // EX/MEM register: takes Execute's results whenever the stage is not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r     <= 1'b0;
            m_alu_r       <= 32'h0000_0000;
            m_wdata_r     <= 32'h0000_0000;
            m_waddr_r     <= 5'd0;
            m_read_r      <= 1'b0;
            m_write_r     <= 1'b0;
            m_to_reg_r    <= 1'b0;
            m_reg_write_r <= 1'b0;
            m_misalign_r  <= 1'b0;
        end else if (!stall_s) begin
            m_valid_r     <= ex_valid;
            m_alu_r       <= ex_alu_result;
            m_wdata_r     <= ex_write_data;
            m_waddr_r     <= ex_write_addr;
            m_read_r      <= ex_mem_read;
            m_write_r     <= ex_mem_write;
            m_to_reg_r    <= ex_mem_to_reg;
            m_reg_write_r <= ex_reg_write;
            m_misalign_r  <= ex_misalign_s;
        end else begin
            m_valid_r     <= m_valid_r;
        end
    end

    // MEM/WB register; the fault flag is written every edge so it can only ever pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_write_addr <= 5'd0;
            wb_write_data <= 32'h0000_0000;
            mem_fault     <= 1'b0;
        end else begin
            mem_fault <= fault_s;
            if (!stall_s) begin
                wb_valid      <= m_valid_r;
                wb_reg_write  <= m_valid_r & m_reg_write_r & ~m_store_s & ~fault_s;
                wb_write_addr <= m_waddr_r;
                wb_write_data <= m_to_reg_r ? dmem.rdata : m_alu_r;
            end else begin
                wb_valid      <= wb_valid;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Randomized self-checking bench for memory_access; expected timing is derived per instruction
// from its memory latency, then unrolled into a per-cycle expectation table.
module tb_memory_access;
    localparam int T     = 15;
    localparam int NOPS  = 150;
    localparam int MAXC  = 4096;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  waddr;
        logic        rd;
        logic        wr;
        logic        to_reg;
        logic        rw;
        int          d;
    } op_t;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_write_data;
    logic [4:0]  ex_write_addr;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic        ex_reg_write;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic        mem_fault;

    memory_access_if dmem_bus ();

    memory_access #(.ACK_TIMEOUT(T), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_write_data (ex_write_data),
        .ex_write_addr (ex_write_addr),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_reg_write  (ex_reg_write),
        .mem_stall     (mem_stall),
        .dmem          (dmem_bus.master),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_write_addr (wb_write_addr),
        .wb_write_data (wb_write_data),
        .mem_fault     (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    op_t ops [NOPS];
    int  t_cap [NOPS];
    int  s_op [NOPS];
    bit  issue_op [NOPS];
    bit  fault_op [NOPS];
    int  in_op [MAXC];
    int  req_op [MAXC];
    int  wb_op [MAXC];
    bit  stall_e [MAXC];
    bit  ack_e [MAXC];
    bit  fault_e [MAXC];
    int  ncyc;
    int  cur_cyc;
    int  n_checks;
    int  n_errors;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=0x%08h exp=0x%08h", tag, cur_cyc, got, exp);
        end
    endtask

    function automatic op_t mk_op(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                                  input logic [4:0] wa, input logic rd, input logic wr,
                                  input logic tr, input logic rw, input int d, input logic [31:0] rdat);
        op_t o;
        o.valid = v; o.alu = alu; o.wdata = wd; o.waddr = wa; o.rd = rd; o.wr = wr;
        o.to_reg = tr; o.rw = rw; o.d = d; o.rdata = rdat;
        return o;
    endfunction

    task automatic build_schedule();
        int t;
        int r;
        logic [31:0] a;
        ops[0] = mk_op(1'b1, 32'h0000_0010, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
        ops[1] = mk_op(1'b1, 32'h0000_0040, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
        ops[2] = mk_op(1'b1, 32'h0000_0044, 32'h1234_5678, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 0, 32'h0);
        ops[3] = mk_op(1'b1, 32'h0000_0044, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h1234_5678);
        ops[4] = mk_op(1'b1, 32'h0000_0048, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 200, 32'h0);
        ops[5] = mk_op(1'b1, 32'h0000_0042, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'hCAFE_F00D);
        for (int i = 6; i < NOPS; i++) begin
            r = $urandom_range(0, 3);
            a = $urandom();
            if ((r >= 2) && ($urandom_range(0, 5) != 0)) a[1:0] = 2'b00;
            ops[i] = mk_op(($urandom_range(0, 7) != 0), a, $urandom(), 5'($urandom()),
                           (r == 2), (r == 3), 1'b0, ($urandom_range(0, 3) != 0), 0, $urandom());
            if ($urandom_range(0, 9) == 0) begin ops[i].rd = 1'b1; ops[i].wr = 1'b1; end
            ops[i].to_reg = ops[i].rd ? 1'b1 : ($urandom_range(0, 4) == 0);
            r = $urandom_range(0, 9);
            ops[i].d = (r == 0) ? 200 : (r == 1) ? T - 1 : (r == 2) ? T - 2 : $urandom_range(0, 4);
            if (i >= NOPS - 2) ops[i].valid = 1'b0;
        end
        // Each op is held on EX until the previous op's memory wait is over.
        t = 0;
        for (int i = 0; i < NOPS; i++) begin
            bit mem;
            bit mis;
            mem = ops[i].valid && (ops[i].rd || ops[i].wr);
            mis = ALIGN_EN && mem && (ops[i].alu[1:0] != 2'b00);
            issue_op[i] = mem && !mis;
            s_op[i]     = issue_op[i] ? ((ops[i].d < T - 1) ? ops[i].d : T - 1) : 0;
            fault_op[i] = mis || (issue_op[i] && ops[i].d >= T);
            t_cap[i]    = t;
            t = t + s_op[i] + 1;
        end
        ncyc = t + 3;
        if (ncyc > MAXC) begin
            $display("FAIL schedule_len cyc=%0d got=%0d exp<=%0d", 0, ncyc, MAXC);
            $fatal(1, "schedule too long");
        end
        for (int c = 0; c < MAXC; c++) begin
            in_op[c] = -1; req_op[c] = -1; wb_op[c] = -1;
            stall_e[c] = 1'b0; ack_e[c] = 1'b0; fault_e[c] = 1'b0;
        end
        for (int i = 0; i < NOPS; i++) begin
            int st;
            int e;
            st = t_cap[i];
            e  = st + s_op[i];
            if (i + 1 < NOPS) for (int c = st; c < t_cap[i + 1]; c++) in_op[c] = i + 1;
            if (issue_op[i]) begin
                for (int c = st; c <= e; c++) req_op[c] = i;
                for (int c = st; c < e; c++) stall_e[c] = 1'b1;
                if (ops[i].d < T) ack_e[st + ops[i].d] = 1'b1;
            end
            for (int c = e + 1; c < ncyc; c++) wb_op[c] = i;
            if (fault_op[i]) fault_e[e + 1] = 1'b1;
        end
    endtask

    task automatic drive_op(input int i);
        if (i < 0) begin
            ex_valid = 1'b0; ex_alu_result = $urandom(); ex_write_data = $urandom();
            ex_write_addr = 5'($urandom()); ex_mem_read = 1'($urandom()); ex_mem_write = 1'($urandom());
            ex_mem_to_reg = 1'($urandom()); ex_reg_write = 1'($urandom());
        end else begin
            ex_valid = ops[i].valid; ex_alu_result = ops[i].alu; ex_write_data = ops[i].wdata;
            ex_write_addr = ops[i].waddr; ex_mem_read = ops[i].rd; ex_mem_write = ops[i].wr;
            ex_mem_to_reg = ops[i].to_reg; ex_reg_write = ops[i].rw;
        end
    endtask

    task automatic check_cycle(input int c);
        int  w;
        int  q;
        bit  store;
        bit  exp_rw;
        check_val("mem_stall", 32'(mem_stall), 32'(stall_e[c]));
        check_val("mem_fault", 32'(mem_fault), 32'(fault_e[c]));
        q = req_op[c];
        check_val("dmem_req", 32'(dmem_bus.req), 32'(q >= 0));
        if (q >= 0) begin
            store = ops[q].wr && !ops[q].rd;
            check_val("dmem_we", 32'(dmem_bus.we), 32'(store));
            check_val("dmem_addr", dmem_bus.addr, ops[q].alu);
            if (store) check_val("dmem_wdata", dmem_bus.wdata, ops[q].wdata);
        end
        w = wb_op[c];
        if (w < 0) begin
            check_val("wb_valid_idle", 32'(wb_valid), 32'd0);
            check_val("wb_reg_write_idle", 32'(wb_reg_write), 32'd0);
        end else begin
            store  = ops[w].wr && !ops[w].rd;
            exp_rw = ops[w].valid && ops[w].rw && !store && !fault_op[w];
            check_val("wb_valid", 32'(wb_valid), 32'(ops[w].valid));
            check_val("wb_reg_write", 32'(wb_reg_write), 32'(exp_rw));
            if (ops[w].valid) begin
                check_val("wb_write_addr", 32'(wb_write_addr), 32'(ops[w].waddr));
                if (!fault_op[w] && (!ops[w].to_reg || (issue_op[w] && !store)))
                    check_val("wb_write_data", wb_write_data,
                              ops[w].to_reg ? ops[w].rdata : ops[w].alu);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req"}, 32'(dmem_bus.req), 32'd0);
        check_val({tag, "_we"}, 32'(dmem_bus.we), 32'd0);
        check_val({tag, "_stall"}, 32'(mem_stall), 32'd0);
        check_val({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        check_val({tag, "_wb_reg_write"}, 32'(wb_reg_write), 32'd0);
        check_val({tag, "_wb_addr"}, 32'(wb_write_addr), 32'd0);
        check_val({tag, "_wb_data"}, wb_write_data, 32'd0);
        check_val({tag, "_fault"}, 32'(mem_fault), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cur_cyc  = -1;
        rst_n    = 1'b0;
        drive_op(-1);
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = 32'h0;
        build_schedule();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        check_val("reset_addr", dmem_bus.addr, 32'd0);
        rst_n = 1'b1;
        drive_op(0);

        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            cur_cyc = c;
            drive_op(in_op[c]);
            dmem_bus.ack   = ack_e[c];
            dmem_bus.rdata = ack_e[c] ? ops[req_op[c]].rdata : $urandom();
            @(negedge clk);
            check_cycle(c);
        end

        // Asynchronous reset in the middle of an outstanding load.
        cur_cyc = -2;
        @(posedge clk); #1;
        drive_op(-1);
        ex_valid = 1'b1; ex_alu_result = 32'h77; ex_write_addr = 5'd3; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_mem_to_reg = 1'b0; ex_reg_write = 1'b1;
        dmem_bus.ack = 1'b0;
        @(posedge clk); #1;
        ex_alu_result = 32'h80; ex_write_addr = 5'd4; ex_mem_read = 1'b1; ex_mem_to_reg = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check_val("pre_rst_req", 32'(dmem_bus.req), 32'd1);
        check_val("pre_rst_stall", 32'(mem_stall), 32'd1);
        check_val("pre_rst_wb_data", wb_write_data, 32'h77);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = 32'h55AA_55AA;
        @(negedge clk);
        check_val("late_ack_req", 32'(dmem_bus.req), 32'd0);
        check_val("late_ack_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        dmem_bus.ack = 1'b0;
        @(negedge clk);
        check_val("late_ack_wb_valid", 32'(wb_valid), 32'd0);
        check_val("late_ack_wb_reg_write", 32'(wb_reg_write), 32'd0);
        check_val("late_ack_fault", 32'(mem_fault), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
